yapp_tx: RTL and testbench
==========================

# yapp_tx

Synthesizable YAPP packet transmitter that drives the router's YAPP input port (`in_data`, `in_data_vld`, `in_suspend`). It buffers one complete packet (header and payload) from an upstream byte stream and appends the XOR parity byte. It then transmits the packet contiguously, honouring the router's `in_suspend` back-pressure. It replaces the testbench-only driver as the producing end of the router's input link in emulation and system builds.

## Interface
- `GAP_CYCLES`, default 1: minimum idle cycles with `in_data_vld`=0 between packets. Legal range 1..15.
- `PKT_CNT_W`, default 16: width of the sent-packet counter.

Ports:
- `clock`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-low.
- `s_data`, in, 8: upstream byte. The first byte of each packet is the header, `{len[5:0], addr[1:0]}`.
- `s_valid`, in, 1: upstream byte valid.
- `s_ready`, out, 1: block accepts `s_data` on an edge where `s_valid` and `s_ready` are both 1.
- `in_data`, out, 8: YAPP byte to the router.
- `in_data_vld`, out, 1: YAPP valid; held high from header through parity.
- `in_suspend`, in, 1: router back-pressure.
- `busy`, out, 1: high whenever the state is not LOAD_HDR.
- `err_len`, out, 1: one-cycle pulse when a zero-length header is received.
- `pkt_count`, out, `PKT_CNT_W`: count of packets whose parity byte has transferred; wraps at 2^`PKT_CNT_W`.
- `force_bad_parity`, in, 1: present only with `YAPP_TX_BAD_PARITY_EN`.

## Operation
- Transfer rule: a byte on `in_data` is consumed by the router on an edge where `in_data_vld`=1 and `in_suspend`=0. Otherwise `in_data` and `in_data_vld` hold.
- Storage: 63×8 payload buffer, 8-bit header register, 8-bit running parity, 6-bit load/send counter.
- States:
  - **LOAD_HDR**
    - `s_ready`=1.
    - On accept with len=0: header is dropped, `err_len` pulses on the next cycle, state stays LOAD_HDR.
    - On accept with len≠0: store header, set parity=header, go to LOAD_PAY.
  - **LOAD_PAY**
    - `s_ready`=1.
    - Each accepted byte is written at buffer[cnt] and XORed into parity.
    - After byte number len is accepted, go to SEND_HDR.
  - **SEND_HDR**
    - `s_ready`=0.
    - Load header into `in_data` and set `in_data_vld`=1, then go to SEND_PAY.
  - **SEND_PAY**
    - On each transfer, load the next buffer byte.
    - On transfer of the last payload byte, load parity and go to SEND_PAR.
  - **SEND_PAR**
    - On transfer: `in_data_vld`←0, `in_data`←0x00, `pkt_count`+1, go to GAP.
  - **GAP**
    - Count `GAP_CYCLES` cycles, then go to LOAD_HDR.
- Address 3 is not filtered; it is transmitted as-is so the router's drop path can be exercised.
- `in_data_vld` never deasserts between header and parity; suspend only stretches a byte.
- Upstream may stall (`s_valid`=0) at any point during load with no effect on the output.

## Timing
- Reset values (edge with `reset`=0):
  - `in_data`=0x00, `in_data_vld`=0, `s_ready`=0 during reset, `busy`=0, `err_len`=0, `pkt_count`=0.
  - State, counter and parity are cleared; buffer contents are don't-care.
- Reset release: `s_ready`=1 on the first cycle with `reset`=1.
- Reset mid-packet: the packet is abandoned and nothing further is sent.
- Latency: last payload byte accepted at edge N → header on `in_data` with `in_data_vld`=1 after edge N+1.
- With `in_suspend`=0 throughout, a len-L packet holds `in_data_vld` high for exactly L+2 cycles.
- `in_suspend` asserted in the same cycle the parity is shown stretches the parity byte; `pkt_count` increments only on the actual transfer edge.
- Inter-packet gap: exactly `GAP_CYCLES` cycles of `in_data_vld`=0 plus the next packet's load time. If the next packet is fully presented on consecutive cycles, the gap is `GAP_CYCLES`+L+2.
- `pkt_count` wraps from all-ones to 0 without a flag.

## Configuration
- `YAPP_TX_BAD_PARITY_EN` defined:
  - Adds the `force_bad_parity` port.
  - The value of `force_bad_parity` on the cycle the parity byte is loaded is used: if it is 1, the transmitted parity is the true parity XOR 0xFF.
  - All other behaviour is unchanged.
- `YAPP_TX_BAD_PARITY_EN` undefined:
  - The port is absent and parity is always correct.

## Test plan
- Header 0x0D (len 3, addr 1), payload 0x11, 0x22, 0x33, `in_suspend`=0 → `in_data` = 0x0D, 0x11, 0x22, 0x33, 0x0D on 5 consecutive cycles with `in_data_vld`=1; then `pkt_count`=1.
- Same packet with `in_suspend` high for 3 cycles while 0x22 is shown → 0x22 held 4 cycles, `in_data_vld` high 8 cycles, parity 0x0D.
- Header 0x02 (len 0) → `err_len` high exactly 1 cycle, `in_data_vld` stays 0, `pkt_count` unchanged, `s_ready` stays 1.
- Header 0xFC (len 63, addr 0) plus 63 bytes 0x01..0x3F, then header 0x07 (len 1, addr 3) plus payload 0xAA:
  - First packet: 65 valid cycles ending in parity 0xFC.
  - `in_data_vld` low for at least 1 cycle between packets.
  - Second packet: 0x07, 0xAA, 0xAD.
  - `pkt_count`=2.
- `reset`=0 while 0x22 of the first scenario is on the bus → after that edge, `in_data_vld`=0, `in_data`=0x00, `pkt_count`=0. After release, a fresh 0x0D packet transmits correctly.
- With `YAPP_TX_BAD_PARITY_EN`, `force_bad_parity`=1, packet 0x0D/0x11/0x22/0x33 → parity byte 0xF2.

Source files
------------

// File: rtl/yapp_tx.sv
// YAPP packet transmitter: buffers one upstream packet, appends XOR parity and
// streams it to the router's YAPP input. Optional YAPP_TX_BAD_PARITY_EN adds force_bad_parity.
module yapp_tx #(
    parameter int GAP_CYCLES = 1,
    parameter int PKT_CNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [7:0]           in_data,
    output logic                 in_data_vld,
    input  logic                 in_suspend,
    output logic                 busy,
    output logic                 err_len,
    output logic [PKT_CNT_W-1:0] pkt_count
`ifdef YAPP_TX_BAD_PARITY_EN
    ,
    input  logic                 force_bad_parity
`endif
);

    typedef enum logic [2:0] {
        LOAD_HDR = 3'd0,
        LOAD_PAY = 3'd1,
        SEND_HDR = 3'd2,
        SEND_PAY = 3'd3,
        SEND_PAR = 3'd4,
        GAP      = 3'd5
    } state_t;

    localparam logic [3:0]           GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [PKT_CNT_W-1:0] PKT_ONE  = PKT_CNT_W'(1);

    state_t               state_q;
    logic [7:0]           hdr_q;
    logic [7:0]           par_q;
    logic [7:0]           in_data_q;
    logic                 in_data_vld_q;
    logic                 err_len_q;
    logic [5:0]           cnt_q;
    logic [3:0]           gap_q;
    logic [PKT_CNT_W-1:0] pkt_count_q;
    logic [7:0]           pay_mem_q [0:62];

    logic                 accept_s;
    logic                 xfer_s;
    logic [5:0]           len_s;
    logic [7:0]           par_mask_s;
    logic [7:0]           par_d;

    assign len_s    = hdr_q[7:2];
    assign accept_s = s_valid && s_ready;
    assign xfer_s   = in_data_vld_q && !in_suspend;

`ifdef YAPP_TX_BAD_PARITY_EN
    assign par_mask_s = force_bad_parity ? 8'hFF : 8'h00;
`else
    assign par_mask_s = 8'h00;
`endif
    assign par_d = par_q ^ par_mask_s;

    // s_ready is gated by reset so it is low while reset is held
    assign s_ready     = reset && ((state_q == LOAD_HDR) || (state_q == LOAD_PAY));
    assign busy        = (state_q != LOAD_HDR);
    assign in_data     = in_data_q;
    assign in_data_vld = in_data_vld_q;
    assign err_len     = err_len_q;
    assign pkt_count   = pkt_count_q;

    // Payload buffer write port; contents need no reset
    always_ff @(posedge clock) begin
        if ((state_q == LOAD_PAY) && accept_s) begin
            pay_mem_q[cnt_q] <= s_data;
        end
    end

    // Main FSM with registered YAPP outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= LOAD_HDR;
            hdr_q         <= 8'h00;
            par_q         <= 8'h00;
            in_data_q     <= 8'h00;
            in_data_vld_q <= 1'b0;
            err_len_q     <= 1'b0;
            cnt_q         <= 6'd0;
            gap_q         <= 4'd0;
            pkt_count_q   <= '0;
        end else begin
            err_len_q <= 1'b0;
            case (state_q)
                LOAD_HDR: begin
                    if (accept_s) begin
                        if (s_data[7:2] == 6'd0) begin
                            err_len_q <= 1'b1;
                        end else begin
                            hdr_q   <= s_data;
                            par_q   <= s_data;
                            cnt_q   <= 6'd0;
                            state_q <= LOAD_PAY;
                        end
                    end
                end
                LOAD_PAY: begin
                    if (accept_s) begin
                        par_q <= par_q ^ s_data;
                        if (cnt_q == (len_s - 6'd1)) begin
                            cnt_q   <= 6'd0;
                            state_q <= SEND_HDR;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                SEND_HDR: begin
                    in_data_q     <= hdr_q;
                    in_data_vld_q <= 1'b1;
                    cnt_q         <= 6'd0;
                    state_q       <= SEND_PAY;
                end
                SEND_PAY: begin
                    // cnt_q is the index of the next byte to show; cnt_q==len means the last payload byte is on the bus
                    if (xfer_s) begin
                        if (cnt_q == len_s) begin
                            in_data_q <= par_d;
                            state_q   <= SEND_PAR;
                        end else begin
                            in_data_q <= pay_mem_q[cnt_q];
                            cnt_q     <= cnt_q + 6'd1;
                        end
                    end
                end
                SEND_PAR: begin
                    if (xfer_s) begin
                        in_data_q     <= 8'h00;
                        in_data_vld_q <= 1'b0;
                        pkt_count_q   <= pkt_count_q + PKT_ONE;
                        gap_q         <= 4'd0;
                        state_q       <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= 4'd0;
                        state_q <= LOAD_HDR;
                    end else begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: begin
                    in_data_q     <= 8'h00;
                    in_data_vld_q <= 1'b0;
                    state_q       <= LOAD_HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yapp_tx.sv
// Directed self-checking bench for yapp_tx: basic send, suspend, zero length,
// reset mid-packet, max length, inter-packet gap and counter wrap.
module tb_yapp_tx;

    localparam int GAP = 2;
    localparam int CW  = 2;

    logic          clock;
    logic          reset;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    in_data;
    logic          in_data_vld;
    logic          in_suspend;
    logic          busy;
    logic          err_len;
    logic [CW-1:0] pkt_count;
`ifdef YAPP_TX_BAD_PARITY_EN
    logic          force_bad_parity;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] pkt_q [$];
    logic [7:0] cap_q [$];
    int         cap_cycles;
    int         cap_hold;
    int         cap_start;
    bit         cap_timeout;

    yapp_tx #(.GAP_CYCLES(GAP), .PKT_CNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .in_data     (in_data),
        .in_data_vld (in_data_vld),
        .in_suspend  (in_suspend),
        .busy        (busy),
        .err_len     (err_len),
        .pkt_count   (pkt_count)
`ifdef YAPP_TX_BAD_PARITY_EN
        ,
        .force_bad_parity (force_bad_parity)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 100) begin
            tick();
            n++;
        end
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL send_byte_timeout: s_ready=%0b required=1", s_ready);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send_pkt();
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
    endtask

    // Collect bytes transferred while in_data_vld is high; suspend susp_n cycles on susp_byte
    task automatic capture(input int susp_n, input logic [7:0] susp_byte);
        int waited = 0;
        int left = susp_n;
        cap_q.delete();
        cap_cycles  = 0;
        cap_hold    = 0;
        cap_timeout = 1'b0;
        while (!in_data_vld && waited < 20) begin
            tick();
            waited++;
        end
        cap_start = cyc;
        if (!in_data_vld) begin
            cap_timeout = 1'b1;
        end else begin
            while (in_data_vld && cap_cycles < 200) begin
                if (in_data == susp_byte) cap_hold++;
                if (left > 0 && in_data == susp_byte) begin
                    in_suspend = 1'b1;
                    left--;
                end else begin
                    in_suspend = 1'b0;
                end
                cap_cycles++;
                if (!in_suspend) cap_q.push_back(in_data);
                tick();
            end
        end
        in_suspend = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        total++; if (in_data !== 8'h00)   begin bad++; $display("FAIL rst_data: got=%h exp=00", in_data); end
        total++; if (in_data_vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got=%b exp=0", in_data_vld); end
        total++; if (s_ready !== 1'b0)     begin bad++; $display("FAIL rst_s_ready: got=%b exp=0", s_ready); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy: got=%b exp=0", busy); end
        total++; if (err_len !== 1'b0)     begin bad++; $display("FAIL rst_err_len: got=%b exp=0", err_len); end
        total++; if (pkt_count !== 2'd0)   begin bad++; $display("FAIL rst_pkt_count: got=%0d exp=0", pkt_count); end
        reset = 1'b1;
        #1;
        total++; if (s_ready !== 1'b1)     begin bad++; $display("FAIL rel_s_ready: got=%b exp=1", s_ready); end
    endtask

    task automatic test_basic(input logic [CW-1:0] exp_cnt);
        logic [7:0] exp [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33};
        send_pkt();
        total++; if (in_data_vld !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_latency: vld=%b busy=%b exp vld=0 busy=1", in_data_vld, busy); end
        tick();
        total++; if (in_data_vld !== 1'b1 || in_data !== 8'h0D) begin bad++; $display("FAIL basic_hdr_next: vld=%b data=%h exp 1/0d", in_data_vld, in_data); end
        capture(0, 8'h00);
        total++; if (cap_timeout) begin bad++; $display("FAIL basic_timeout: no valid seen exp valid"); end
        total++; if (cap_cycles != 5) begin bad++; $display("FAIL basic_vld_cycles: got=%0d exp=5", cap_cycles); end
        total++; if (cap_q.size() != 5) begin bad++; $display("FAIL basic_len: got=%0d exp=5", cap_q.size()); end
        else for (int i = 0; i < 5; i++) begin
            total++; if (cap_q[i] !== exp[i]) begin bad++; $display("FAIL basic_byte%0d: got=%h exp=%h", i, cap_q[i], exp[i]); end
        end
        total++; if (pkt_count !== exp_cnt || in_data !== 8'h00) begin bad++; $display("FAIL basic_count: cnt=%0d data=%h exp %0d/00", pkt_count, in_data, exp_cnt); end
    endtask

    task automatic test_suspend();
        logic [7:0] exp [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33};
        send_pkt();
        capture(3, 8'h22);
        total++; if (cap_cycles != 8) begin bad++; $display("FAIL susp_vld_cycles: got=%0d exp=8", cap_cycles); end
        total++; if (cap_hold != 4) begin bad++; $display("FAIL susp_hold: got=%0d exp=4", cap_hold); end
        total++; if (cap_q.size() != 5) begin bad++; $display("FAIL susp_len: got=%0d exp=5", cap_q.size()); end
        else for (int i = 0; i < 5; i++) begin
            total++; if (cap_q[i] !== exp[i]) begin bad++; $display("FAIL susp_byte%0d: got=%h exp=%h", i, cap_q[i], exp[i]); end
        end
        total++; if (pkt_count !== 2'd2) begin bad++; $display("FAIL susp_count: got=%0d exp=2", pkt_count); end
        repeat (GAP) tick();
    endtask

    task automatic test_zero_len();
        total++; if (err_len !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL zl_pre: err=%b rdy=%b exp 0/1", err_len, s_ready); end
        send_byte(8'h02);
        total++; if (err_len !== 1'b1) begin bad++; $display("FAIL zl_pulse: got=%b exp=1", err_len); end
        total++; if (s_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zl_state: rdy=%b busy=%b exp 1/0", s_ready, busy); end
        tick();
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL zl_one_cycle: got=%b exp=0", err_len); end
        repeat (3) tick();
        total++; if (in_data_vld !== 1'b0 || pkt_count !== 2'd2 || s_ready !== 1'b1) begin bad++; $display("FAIL zl_after: vld=%b cnt=%0d rdy=%b exp 0/2/1", in_data_vld, pkt_count, s_ready); end
    endtask

    task automatic test_parity_stretch();
        int n = 0;
        pkt_q = '{8'h07, 8'hAA};
        send_pkt();
        while (!(in_data_vld && in_data == 8'hAD) && n < 20) begin tick(); n++; end
        total++; if (in_data !== 8'hAD) begin bad++; $display("FAIL ps_parity: got=%h exp=ad", in_data); end
        in_suspend = 1'b1;
        repeat (2) tick();
        total++; if (in_data_vld !== 1'b1 || in_data !== 8'hAD || pkt_count !== 2'd2) begin bad++; $display("FAIL ps_hold: vld=%b data=%h cnt=%0d exp 1/ad/2", in_data_vld, in_data, pkt_count); end
        in_suspend = 1'b0;
        tick();
        total++; if (in_data_vld !== 1'b0 || pkt_count !== 2'd3) begin bad++; $display("FAIL ps_xfer: vld=%b cnt=%0d exp 0/3", in_data_vld, pkt_count); end
        repeat (GAP) tick();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit seen = 1'b0;
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33};
        send_pkt();
        while (!(in_data_vld && in_data == 8'h22) && n < 20) begin tick(); n++; end
        total++; if (in_data !== 8'h22) begin bad++; $display("FAIL rm_reach: got=%h exp=22", in_data); end
        reset = 1'b0;
        tick();
        total++; if (in_data_vld !== 1'b0 || in_data !== 8'h00 || pkt_count !== 2'd0) begin bad++; $display("FAIL rm_clear: vld=%b data=%h cnt=%0d exp 0/00/0", in_data_vld, in_data, pkt_count); end
        reset = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (in_data_vld) seen = 1'b1;
            tick();
        end
        total++; if (seen) begin bad++; $display("FAIL rm_quiet: valid seen after reset exp none"); end
    endtask

    task automatic test_max_len_and_gap();
        int end_cyc;
        logic [7:0] exp2 [3] = '{8'h07, 8'hAA, 8'hAD};
        pkt_q = '{8'hFC};
        for (int i = 1; i <= 63; i++) pkt_q.push_back(8'(i));
        send_pkt();
        capture(0, 8'h00);
        end_cyc = cyc;
        total++; if (cap_cycles != 65 || cap_q.size() != 65) begin bad++; $display("FAIL max_cycles: cyc=%0d bytes=%0d exp 65/65", cap_cycles, cap_q.size()); end
        else begin
            total++; if (cap_q[0] !== 8'hFC || cap_q[64] !== 8'hFC) begin bad++; $display("FAIL max_hdr_par: hdr=%h par=%h exp fc/fc", cap_q[0], cap_q[64]); end
            for (int i = 1; i <= 63; i++) begin
                total++; if (cap_q[i] !== 8'(i)) begin bad++; $display("FAIL max_byte%0d: got=%h exp=%h", i, cap_q[i], 8'(i)); end
            end
        end
        pkt_q = '{8'h07, 8'hAA};
        send_pkt();
        capture(0, 8'h00);
        total++; if (cap_start - end_cyc != GAP + 3) begin bad++; $display("FAIL gap_len: got=%0d exp=%0d", cap_start - end_cyc, GAP + 3); end
        total++; if (cap_q.size() != 3) begin bad++; $display("FAIL a3_len: got=%0d exp=3", cap_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            total++; if (cap_q[i] !== exp2[i]) begin bad++; $display("FAIL a3_byte%0d: got=%h exp=%h", i, cap_q[i], exp2[i]); end
        end
        total++; if (pkt_count !== 2'd3) begin bad++; $display("FAIL max_count: got=%0d exp=3", pkt_count); end
        repeat (GAP) tick();
    endtask

`ifdef YAPP_TX_BAD_PARITY_EN
    task automatic test_bad_parity();
        force_bad_parity = 1'b1;
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33};
        send_pkt();
        capture(0, 8'h00);
        force_bad_parity = 1'b0;
        total++; if (cap_q.size() != 5) begin bad++; $display("FAIL bp_len: got=%0d exp=5", cap_q.size()); end
        else begin
            total++; if (cap_q[4] !== 8'hF2) begin bad++; $display("FAIL bp_parity: got=%h exp=f2", cap_q[4]); end
        end
        repeat (GAP) tick();
    endtask
`endif

    initial begin
        reset      = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        in_suspend = 1'b0;
`ifdef YAPP_TX_BAD_PARITY_EN
        force_bad_parity = 1'b0;
`endif
        test_reset();
        test_basic(2'd1);
        repeat (GAP) tick();
        test_suspend();
        test_zero_len();
        test_parity_stretch();
        test_reset_mid();
        test_basic(2'd1);
        repeat (GAP) tick();
        test_max_len_and_gap();
        test_basic(2'd0);
        repeat (GAP) tick();
`ifdef YAPP_TX_BAD_PARITY_EN
        test_bad_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
